// File: rtl/ps2_host_tx_if.sv
// Requester-side handshake and status bundle for the PS/2 host transmitter.
// The requester drives the master modport; the transmitter uses the slave modport.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       err;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, busy, done, ack_ok, err
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, busy, done, ack_ok, err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop, then samples the device ACK; lines are driven open-drain.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  bus,
   input  logic          i_ps2_clk,
   input  logic          i_ps2_data,
   output logic          o_ps2_clk_oe,
   output logic          o_ps2_data_oe
);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

   localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_clkSync;
   logic [1:0]  r_dataSync;
   logic [31:0] r_count;
   logic [8:0]  r_frame;
   logic [3:0]  r_bitCnt;
   logic        r_dataOe;
   logic        r_ackBit;
   logic        r_ackOk;
   logic        r_done;
   logic        r_err;

   logic w_fall;
   logic w_idleBus;
   logic w_ready;
   logic w_accept;
   logic w_timing;
   logic w_timeout;

   assign w_fall    = r_clkSync[2] & ~r_clkSync[1];
   assign w_idleBus = r_clkSync[1] & r_dataSync[1];
   // Hold off tx_ready during the done/err pulse cycle so it returns one cycle later
   assign w_ready   = (r_state == IDLE) & ~r_done & ~r_err;
   assign w_accept  = bus.tx_valid & w_ready;
   assign w_timing  = (r_state == SHIFT) | (r_state == ACK) | (r_state == WAIT_IDLE);
   assign w_timeout = w_timing & ~w_fall & (r_count == TIMEOUT_LAST);

   assign bus.tx_ready  = w_ready;
   assign bus.busy      = ~w_ready;
   assign bus.done      = r_done;
   assign bus.ack_ok    = r_ackOk;
   assign bus.err       = r_err;
   assign o_ps2_clk_oe  = (r_state == INHIBIT) | (r_state == REQ);
   assign o_ps2_data_oe = r_dataOe;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_accept) w_next = INHIBIT;
         INHIBIT:   if (r_count == INHIBIT_LAST) w_next = REQ;
         REQ:       w_next = SHIFT;
         SHIFT: begin
            if (w_timeout) w_next = IDLE;
            else if (w_fall && r_bitCnt == 4'd9) w_next = ACK;
         end
         ACK: begin
            if (w_timeout) w_next = IDLE;
            else if (w_fall) w_next = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (w_idleBus) w_next = IDLE;
            else if (w_timeout) w_next = IDLE;
         end
         default:   w_next = IDLE;
      endcase
   end

   // The frame register shifts right and refills with ones, so bit 0 is always the next bit out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clkSync  <= 3'b111;
         r_dataSync <= 2'b11;
         r_count    <= '0;
         r_frame    <= '1;
         r_bitCnt   <= '0;
         r_dataOe   <= 1'b0;
         r_ackBit   <= 1'b0;
         r_ackOk    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_clkSync  <= {r_clkSync[1:0], i_ps2_clk};
         r_dataSync <= {r_dataSync[0], i_ps2_data};
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_frame  <= {~^bus.tx_data, bus.tx_data};
                  r_bitCnt <= '0;
                  r_count  <= '0;
                  r_dataOe <= 1'b0;
               end
            end
            INHIBIT: begin
               r_count <= r_count + 32'd1;
               if (r_count == INHIBIT_LAST) r_dataOe <= 1'b1;
            end
            REQ: r_count <= '0;
            SHIFT: begin
               if (w_fall) begin
                  r_count  <= '0;
                  r_bitCnt <= r_bitCnt + 4'd1;
                  if (r_bitCnt == 4'd9) begin
                     r_dataOe <= 1'b0;
                  end else begin
                     r_dataOe <= ~r_frame[0];
                     r_frame  <= {1'b1, r_frame[8:1]};
                  end
               end else if (w_timeout) begin
                  r_err    <= 1'b1;
                  r_dataOe <= 1'b0;
               end else begin
                  r_count <= r_count + 32'd1;
               end
            end
            ACK: begin
               if (w_fall) begin
                  r_count  <= '0;
                  r_ackBit <= ~r_dataSync[1];
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_count <= r_count + 32'd1;
               end
            end
            WAIT_IDLE: begin
               if (w_idleBus) begin
                  r_done  <= 1'b1;
                  r_ackOk <= r_ackBit;
               end else if (w_fall) begin
                  r_count <= '0;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_count <= r_count + 32'd1;
               end
            end
            default: r_dataOe <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte from the board to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It sits next to `ps2_keyboard` on the shared ps2_clk/ps2_data pins and drives them open-drain through output-enable lines. It runs the full host request sequence: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK. It reports completion or a timeout to the requester.

## Interface
- INHIBIT_CYCLES, default 5000: cycles ps2_clk is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, default 1000000: maximum cycles allowed between consecutive device clock falling edges, or while waiting for the bus to go idle (20 ms at 50 MHz).
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_valid, input, 1: requester has a byte to send.
- tx_data, input, 8: command byte; captured on acceptance.
- tx_ready, output, 1: high only in IDLE; a byte is accepted on any cycle where tx_valid and tx_ready are both high.
- ps2_clk_i, input, 1: raw PS/2 clock pin level.
- ps2_data_i, input, 1: raw PS/2 data pin level.
- ps2_clk_oe, output, 1: 1 pulls the clock pin low; 0 releases it.
- ps2_data_oe, output, 1: 1 pulls the data pin low; 0 releases it.
- busy, output, 1: equals ~tx_ready.
- done, output, 1: one-cycle pulse when a transfer completes normally.
- ack_ok, output, 1: valid with done; 1 if the device drove the ACK bit low.
- err, output, 1: one-cycle pulse on timeout; the transfer is aborted.

## Operation
- ps2_clk_i passes through a 3-flop shift register s[2:0]. A falling edge is detected in the cycle where s[2]=1 and s[1]=0. ps2_data_i uses a matching 2-flop synchronizer.
- Parity bit = ~^tx_data (odd parity). The frame shifts LSB first.
- States and outputs:
  - IDLE: tx_ready=1, both oe=0. On acceptance, latch tx_data and parity, clear bit counter and timer, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit) for 1 cycle, then go to SHIFT. Clock is released in the next state.
  - SHIFT: clk_oe=0. On each detected falling edge n=1..9, data_oe = ~bit, where bits 1..8 are tx_data[0..7] and bit 9 is parity. On edge 10, data_oe=0 (stop bit = 1) and go to ACK. data_oe holds its value between edges.
  - ACK: on the next falling edge, sample synchronized data: ack_ok = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: once synchronized clock and data are both 1, pulse done for one cycle with ack_ok, then go to IDLE.
- Timer: counts in SHIFT, ACK and WAIT_IDLE, and clears on every detected falling edge. If it reaches TIMEOUT_CYCLES, pulse err, release both lines, go to IDLE; done does not pulse.
- tx_valid while busy is ignored; tx_data changes after acceptance have no effect.
- Reset mid-transfer: on the next clock both oe=0, state=IDLE, done=err=0, and the latched byte is discarded.

## Timing
- Reset values: tx_ready=1, busy=0, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, err=0.
- Acceptance at edge k: clk_oe=1 from cycle k+1 through k+INHIBIT_CYCLES; REQ occupies cycle k+INHIBIT_CYCLES+1; clk_oe=0 from k+INHIBIT_CYCLES+2.
- Pin falling edge to data_oe update: 3 cycles (2 synchronizer flops plus the registered output).
- done/err are registered pulses. tx_ready returns to 1 in the cycle after the pulse.
- ack_ok holds its value until the next done.

## Test plan
- Send 0xED with a device model that clocks at 10 kHz and ACKs. Required: start bit, then data bits 1,0,1,1,0,1,1,1, then parity 1 and stop 1 on the pin; done=1 with ack_ok=1; inhibit window exactly INHIBIT_CYCLES cycles.
- Send 0x01 (parity 0) and 0x00 (parity 1). Required: the device model sees a correct frame each time; a back-to-back second tx_valid is accepted only after tx_ready returns to 1.
- Device model never ACKs (data stays high on edge 11). Required: done=1 with ack_ok=0, err=0.
- Device model stops clocking after 4 edges, with TIMEOUT_CYCLES=200. Required: err pulses 200 cycles after the 4th detected edge; both oe=0; tx_ready=1; no done pulse.
- Assert rst during SHIFT. Required: both oe=0 on the next clock, tx_ready=1, no done/err pulse. A following 0xFF transfer completes with ack_ok=1.
- Hold tx_valid with changing tx_data while busy. Required: only the byte present at acceptance is transmitted; no extra acceptances.
